// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
//   Shared definitions for the iterative divider that sits beside the ALU in
//   the execute stage.
//   - div_state_e : 2-bit FSM encoding (DIV_IDLE / DIV_CALC / DIV_DONE)
//   - ALU_*       : ALU operation codes. DIV/DIVU get their own codes so the
//                   ALU decoder no longer maps them onto the null operation.
//   - is_div_op() : helper used by the decoder to steer an op to the divider.
// -----------------------------------------------------------------------------
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [5:0] ALU_NOP  = 6'b000000;
    localparam logic [5:0] ALU_DIV  = 6'b011010;
    localparam logic [5:0] ALU_DIVU = 6'b011011;

    function automatic logic is_div_op(input logic [5:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Iterative radix-2 restoring divider for DIV (signed) and DIVU (unsigned).
//   One quotient bit is produced per clock; the pipeline stalls while busy.
//   The quotient goes to LO and the remainder to HI.
//
//   Ports
//     clk        : rising-edge clock
//     rst        : synchronous active-high reset
//     start      : request a division (sampled at posedge)
//     signed_div : 1 = DIV (two's complement), 0 = DIVU; sampled with start
//     dividend   : rs operand; sampled with start
//     divisor    : rt operand; sampled with start
//     cancel     : abort the running operation (exception / flush)
//     busy       : high while the FSM is not idle
//     valid      : one-cycle result strobe
//     quotient   : result for LO; held until the next completed operation
//     remainder  : result for HI; held until the next completed operation
//
//   Timing: start accepted in cycle 0 -> CALC in cycles 1..WIDTH -> DONE
//   (valid) in cycle WIDTH+1. A zero divisor skips CALC and reports in cycle 1
//   with quotient = all ones and remainder = the raw dividend.
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    div_state_e       state;
    div_state_e       state_next;

    logic [CNT_W-1:0] cnt;        // completed restoring steps
    logic [WIDTH-1:0] rem;        // partial remainder (magnitude)
    logic [WIDTH-1:0] quo;        // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvs;        // divisor magnitude
    logic             sign_q;     // negate quotient at the end
    logic             sign_r;     // negate remainder at the end

    logic             accept;     // start taken this cycle
    logic             step;       // one restoring step this cycle
    logic             last_step;  // this step produces the final quotient bit
    logic             div_zero;

    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

    logic [WIDTH:0]   shifted;    // {rem, next dividend bit}
    logic [WIDTH:0]   diff;       // shifted - divisor, MSB is the borrow
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // -------------------------------------------------------------------------
    // Operand conditioning
    // -------------------------------------------------------------------------
    // The most negative value has no positive counterpart, but its negation
    // is the same bit pattern, which is its correct unsigned magnitude. That is
    // why MIN / -1 yields MIN without any special-case logic.
    assign dividend_neg = signed_div & dividend[WIDTH-1];
    assign divisor_neg  = signed_div & divisor[WIDTH-1];
    assign dividend_mag = dividend_neg ? -dividend : dividend;
    assign divisor_mag  = divisor_neg  ? -divisor  : divisor;
    assign div_zero     = (divisor == '0);

    // -------------------------------------------------------------------------
    // Restoring step
    // -------------------------------------------------------------------------
    // The partial remainder is always below the divisor, so after the shift it
    // fits in WIDTH+1 bits and a WIDTH+1 bit subtract is enough: the MSB of the
    // difference is set exactly when the trial subtraction goes negative.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        rem_step = shifted[WIDTH-1:0];
        quo_step = {quo[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_step = diff[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], 1'b1};
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and control
    // -------------------------------------------------------------------------
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;

        unique case (state)
            DIV_IDLE: begin
                // cancel is meaningless while idle
                accept = start;
            end
            DIV_CALC: begin
                // start is ignored mid-operation
                if (cancel) begin
                    state_next = DIV_IDLE;
                end else begin
                    step = 1'b1;
                    if (last_step) begin
                        state_next = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                // cancel beats a back-to-back start in the same cycle
                if (cancel) begin
                    state_next = DIV_IDLE;
                end else if (start) begin
                    accept = 1'b1;
                end else begin
                    state_next = DIV_IDLE;
                end
            end
            default: begin
                state_next = DIV_IDLE;
            end
        endcase

        if (accept) begin
            state_next = div_zero ? DIV_DONE : DIV_CALC;
        end
    end

    assign busy  = (state != DIV_IDLE);
    // A flush arriving in the result cycle must keep the result from being
    // written back, hence the combinational qualification.
    assign valid = (state == DIV_DONE) && !cancel;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= dividend_mag;
            dvs    <= divisor_mag;
            sign_q <= dividend_neg ^ divisor_neg;
            sign_r <= dividend_neg;
            // Divide-by-zero reports immediately, independent of signed_div.
            if (div_zero) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (step) begin
            cnt <= cnt + CNT_W'(1);
            rem <= rem_step;
            quo <= quo_step;
            // Results are fixed up and registered on the edge into DONE, so
            // they are stable for the whole valid cycle and held afterwards.
            if (last_step) begin
                quotient  <= sign_q ? -quo_step : quo_step;
                remainder <= sign_r ? -rem_step : rem_step;
            end
        end
    end

endmodule
